// File: rtl/multiplex_sequencial_if.sv
// Channel-selector bus: data channels, select/scan controls and the registered sample outputs.
interface multiplex_sequencial_if #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned DWELL_W = 4
);
    logic                     EN;
    logic                     MODE;
    logic [N_CH*DATA_W-1:0]   D;
    logic [SEL_W-1:0]         S;
    logic [N_CH-1:0]          MASK;
    logic [DWELL_W-1:0]       DWELL;
    logic [DATA_W-1:0]        Y;
    logic [SEL_W-1:0]         CH;
    logic                     VALID;
    logic                     ERR;

    modport master (
        output EN, MODE, D, S, MASK, DWELL,
        input  Y, CH, VALID, ERR
    );

    modport slave (
        input  EN, MODE, D, S, MASK, DWELL,
        output Y, CH, VALID, ERR
    );
endinterface

// File: rtl/multiplex_sequencial.sv
// N-channel registered multiplexer: manual select by S, or an auto-scan sequencer that
// walks the MASK-enabled channels with a programmable dwell and tags each sample.
module multiplex_sequencial #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned DWELL_W = 4
) (
    input logic                   CLK,
    input logic                   RST,
    multiplex_sequencial_if.slave bus
);

    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_e;

    mode_e               mode;
    logic [DATA_W-1:0]   d_arr [N_CH];
    logic [DATA_W-1:0]   y_q;
    logic [SEL_W-1:0]    ch_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [SEL_W-1:0]    ptr_nxt;
    logic [SEL_W-1:0]    lo_any;
    logic [SEL_W-1:0]    lo_above;
    logic                got_any;
    logic                got_above;
    logic [DWELL_W-1:0]  cnt_q;
    logic                valid_q;
    logic                err_q;
    logic                s_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign d_arr[k] = bus.D[k*DATA_W +: DATA_W];
    end

    assign mode = mode_e'(bus.MODE);
    assign s_ok = 32'(bus.S) < N_CH;

    // Next scan channel: lowest enabled index above ptr, else lowest enabled overall.
    always_comb begin
        lo_any    = ptr_q;
        lo_above  = ptr_q;
        got_any   = 1'b0;
        got_above = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.MASK[SEL_W'(i)]) begin
                if (!got_any) begin
                    lo_any  = SEL_W'(i);
                    got_any = 1'b1;
                end
                if (!got_above && i > 32'(ptr_q)) begin
                    lo_above  = SEL_W'(i);
                    got_above = 1'b1;
                end
            end
        end
        ptr_nxt = got_above ? lo_above : lo_any;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_q     <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (!bus.EN) begin
            valid_q <= 1'b0;
        end else if (mode == MANUAL) begin
            cnt_q <= '0;
            if (s_ok) begin
                y_q     <= d_arr[bus.S];
                ch_q    <= bus.S;
                ptr_q   <= bus.S;
                valid_q <= 1'b1;
                err_q   <= 1'b0;
            end else begin
                y_q     <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b1;
            end
        end else if (bus.MASK == '0) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // The current channel is sampled for its whole dwell even if it was just masked off.
            y_q   <= d_arr[ptr_q];
            ch_q  <= ptr_q;
            err_q <= 1'b0;
            if (cnt_q == bus.DWELL) begin
                valid_q <= 1'b1;
                cnt_q   <= '0;
                ptr_q   <= ptr_nxt;
            end else begin
                valid_q <= 1'b0;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.Y     = y_q;
    assign bus.CH    = ch_q;
    assign bus.VALID = valid_q;
    assign bus.ERR   = err_q;

endmodule

// File: tb/tb_multiplex_sequencial.sv
// Bench for multiplex_sequencial: directed scenarios plus random traffic against a channel-level model.
module tb_multiplex_sequencial;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    multiplex_sequencial_if #(.N_CH(4), .SEL_W(2), .DATA_W(8), .DWELL_W(4)) i4 ();
    multiplex_sequencial_if #(.N_CH(3), .SEL_W(2), .DATA_W(8), .DWELL_W(4)) i3 ();

    multiplex_sequencial #(.N_CH(4), .SEL_W(2), .DATA_W(8), .DWELL_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .bus(i4)
    );
    multiplex_sequencial #(.N_CH(3), .SEL_W(2), .DATA_W(8), .DWELL_W(4)) dut3 (
        .CLK(CLK), .RST(RST), .bus(i3)
    );

    // Model state for the 4-channel instance
    int         m_ptr, m_cnt, m_ch;
    logic [7:0] m_y;
    bit         m_valid, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] chan(input int k);
        logic [31:0] dv;
        dv = i4.D >> (k * 8);
        return dv[7:0];
    endfunction

    // Rotating search from p+1 around the ring; returns p when it is the only enabled channel.
    function automatic int next_ch(input int p, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (((m >> c) & 4'd1) != 4'd0) return c;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_ch = 0; m_y = 8'h00; m_valid = 0; m_err = 0;
    endtask

    task automatic model_step();
        if (!i4.EN) begin
            m_valid = 0;
        end else if (!i4.MODE) begin
            m_cnt = 0; m_y = chan(int'(i4.S)); m_ch = int'(i4.S); m_ptr = m_ch;
            m_valid = 1; m_err = 0;
        end else if (i4.MASK == 4'd0) begin
            m_cnt = 0; m_valid = 0; m_err = 0;
        end else begin
            m_y = chan(m_ptr); m_ch = m_ptr; m_err = 0;
            if (m_cnt == int'(i4.DWELL)) begin
                m_valid = 1; m_cnt = 0; m_ptr = next_ch(m_ptr, i4.MASK);
            end else begin
                m_valid = 0; m_cnt = (m_cnt + 1) % 16;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".Y"},     32'(i4.Y),     32'(m_y));
        chk({tag, ".CH"},    32'(i4.CH),    32'(m_ch));
        chk({tag, ".VALID"}, 32'(i4.VALID), 32'(m_valid));
        chk({tag, ".ERR"},   32'(i4.ERR),   32'(m_err));
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        check_state(tag);
    endtask

    initial begin
        int auto_ch [13];
        int mask_ch [5];
        logic [7:0] man_y [4];
        logic [7:0] held_y;
        auto_ch = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        mask_ch = '{0, 1, 3, 1, 3};
        man_y   = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        i4.EN = 1'b1; i4.MODE = 1'b0; i4.S = 2'd0; i4.MASK = 4'hF; i4.DWELL = 4'd0;
        i4.D  = 32'hD3C2B1A0;
        i3.EN = 1'b1; i3.MODE = 1'b0; i3.S = 2'd0; i3.MASK = 3'b111; i3.DWELL = 4'd0;
        i3.D  = 24'hC2B1A0;
        model_reset();

        // Reset held across edges with nonzero data
        repeat (2) @(posedge CLK);
        #1;
        check_state("reset");
        chk("reset3.ERR", 32'(i3.ERR), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Manual select of every channel
        for (int k = 0; k < 4; k++) begin
            i4.S = 2'(k);
            tick("manual");
            chk("manual_y", 32'(i4.Y), 32'(man_y[k]));
            chk("manual_ch", 32'(i4.CH), 32'(k));
        end

        // Out-of-range select on the 3-channel instance
        i3.S = 2'd2;
        tick("oor_pre");
        chk("oor_pre.Y", 32'(i3.Y), 32'hC2);
        chk("oor_pre.VALID", 32'(i3.VALID), 32'd1);
        i3.S = 2'd3;
        tick("oor");
        chk("oor.Y", 32'(i3.Y), 32'd0);
        chk("oor.ERR", 32'(i3.ERR), 32'd1);
        chk("oor.VALID", 32'(i3.VALID), 32'd0);
        chk("oor.CH", 32'(i3.CH), 32'd2);
        i3.S = 2'd1;
        tick("oor_post");
        chk("oor_post.ERR", 32'(i3.ERR), 32'd0);
        chk("oor_post.Y", 32'(i3.Y), 32'hB1);
        chk("oor_post.CH", 32'(i3.CH), 32'd1);

        // Full-mask scan, dwell 2, from channel 0
        i4.S = 2'd0;
        tick("pre_auto");
        i4.MODE = 1'b1; i4.MASK = 4'hF; i4.DWELL = 4'd2;
        for (int k = 0; k < 13; k++) begin
            tick("auto");
            chk("auto_ch", 32'(i4.CH), 32'(auto_ch[k]));
            chk("auto_valid", 32'(i4.VALID), ((k % 3) == 2) ? 32'd1 : 32'd0);
        end

        // Sparse mask, dwell 0, then mask cleared mid-scan
        i4.MODE = 1'b0; i4.S = 2'd0;
        tick("pre_mask");
        i4.MODE = 1'b1; i4.MASK = 4'b1010; i4.DWELL = 4'd0;
        for (int k = 0; k < 5; k++) begin
            tick("masked");
            chk("masked_ch", 32'(i4.CH), 32'(mask_ch[k]));
            chk("masked_valid", 32'(i4.VALID), 32'd1);
        end
        held_y = i4.Y;
        i4.MASK = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick("mask0");
            chk("mask0_ch", 32'(i4.CH), 32'd3);
            chk("mask0_y", 32'(i4.Y), 32'hD3);
            chk("mask0_valid", 32'(i4.VALID), 32'd0);
        end
        chk("mask0_y_held", 32'(held_y), 32'hD3);

        // Enable low mid-dwell: state frozen, dwell resumes at the same count
        i4.MODE = 1'b0; i4.S = 2'd1;
        tick("pre_en");
        i4.MODE = 1'b1; i4.MASK = 4'hF; i4.DWELL = 4'd3;
        tick("en_a");
        tick("en_b");
        i4.EN = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("en_off");
            chk("en_off_ch", 32'(i4.CH), 32'd1);
            chk("en_off_valid", 32'(i4.VALID), 32'd0);
        end
        i4.EN = 1'b1;
        tick("en_r1");
        chk("en_r1_valid", 32'(i4.VALID), 32'd0);
        tick("en_r2");
        chk("en_r2_valid", 32'(i4.VALID), 32'd1);
        chk("en_r2_ch", 32'(i4.CH), 32'd1);
        tick("en_r3");
        chk("en_r3_ch", 32'(i4.CH), 32'd2);

        // Manual -> auto resumes from the last manual channel
        i4.MODE = 1'b0; i4.S = 2'd2;
        tick("sw_man");
        i4.MODE = 1'b1;
        tick("sw_auto");
        chk("sw_auto_ch", 32'(i4.CH), 32'd2);
        chk("sw_auto_y", 32'(i4.Y), 32'hC2);

        // Asynchronous reset mid-scan, between edges
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        tick("post_rst");
        chk("post_rst_ch", 32'(i4.CH), 32'd0);
        chk("post_rst_y", 32'(i4.Y), 32'hA0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            i4.EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) i4.MODE = ~i4.MODE;
            i4.S = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) i4.MASK = 4'($urandom);
            if ($urandom_range(0, 5) == 0)
                i4.DWELL = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            i4.D = $urandom;
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
